// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: sequencer states, the hazard control word
// and the register-zero constant reused by the hazard and forwarding logic.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_STEP     = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } hazard_ctrl_t;

    // All-zero control word: nothing written, nothing flushed.
    localparam hazard_ctrl_t BUBBLE = '0;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use compare between the lw in EX and the sources of the
// instruction in ID.
module load_use_detector
    import mips_pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    // $zero never carries a real dependency, so a lw into it cannot stall.
    always_comb begin
        hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                 ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: derives every pipeline-register enable/flush from
// memory waits, redirects, load-use hazards, jumps and the debug port.
module pipeline_hazard_controller
    import mips_pipe_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           if_id_rs,
    input  logic [4:0]           if_id_rt,
    input  logic                 id_uses_rt,
    input  logic                 id_jump,
    input  logic                 id_ex_mem_read,
    input  logic [4:0]           id_ex_rt,
    input  logic                 ex_redirect,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic                 halt_req,
    input  logic                 resume,
    input  logic                 step,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 id_ex_write,
    output logic                 ex_mem_write,
    output logic                 mem_wb_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 halted,
    output logic                 mem_error,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int WI_W   = WAIT_W + 1;

    pipe_state_e          state;
    pipe_state_e          next_state;
    hazard_ctrl_t         ctrl;
    logic                 load_use;
    logic                 mem_wait;
    logic                 freeze;
    logic                 timeout;
    logic                 ret_halt;
    logic                 mem_error_q;
    logic                 stall_inc;
    logic                 flush_inc;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [WI_W-1:0]      wait_index;
    logic [CNT_WIDTH-1:0] stall_q;
    logic [CNT_WIDTH-1:0] flush_q;

    load_use_detector u_load_use (
        .rs          (if_id_rs),
        .rt          (if_id_rt),
        .uses_rt     (id_uses_rt),
        .ex_mem_read (id_ex_mem_read),
        .ex_rt       (id_ex_rt),
        .hazard      (load_use)
    );

    // wait_index is the 1-based number of the wait cycle currently in progress.
    always_comb begin
        mem_wait   = mem_req && !mem_ready;
        freeze     = (state != ST_HALT) && mem_wait;
        wait_index = (state == ST_MEM_WAIT) ? ({1'b0, wait_cnt} + WI_W'(1)) : WI_W'(1);
        timeout    = freeze && (wait_index >= WI_W'(MEM_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    next_state = timeout ? ST_HALT : ST_MEM_WAIT;
                end else if (halt_req) begin
                    next_state = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                if (timeout) begin
                    next_state = ST_HALT;
                end else if (!mem_wait) begin
                    next_state = (ret_halt || halt_req) ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    next_state = ST_RUN;
                end else if (step) begin
                    next_state = ST_STEP;
                end
            end
            ST_STEP: begin
                if (mem_wait) begin
                    next_state = timeout ? ST_HALT : ST_MEM_WAIT;
                end else begin
                    next_state = ST_HALT;
                end
            end
            default: next_state = ST_RUN;
        endcase
    end

    // Priority: reset, halt, memory freeze, redirect, load-use, jump.
    always_comb begin
        ctrl      = BUBBLE;
        halted    = 1'b0;
        stall_inc = 1'b0;
        if (reset) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
        end else if (state == ST_HALT) begin
            halted = 1'b1;
        end else if (mem_wait) begin
            stall_inc = 1'b1;
        end else begin
            ctrl.pc_write     = 1'b1;
            ctrl.if_id_write  = 1'b1;
            ctrl.id_ex_write  = 1'b1;
            ctrl.ex_mem_write = 1'b1;
            ctrl.mem_wb_write = 1'b1;
            if (ex_redirect) begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end else if (load_use) begin
                ctrl.pc_write    = 1'b0;
                ctrl.if_id_write = 1'b0;
                ctrl.id_ex_flush = 1'b1;
                stall_inc        = 1'b1;
            end else if (id_jump) begin
                ctrl.if_id_flush = 1'b1;
            end
        end
        flush_inc = !reset && (ctrl.if_id_flush || ctrl.id_ex_flush || ctrl.ex_mem_flush);
    end

    // A wait entered from STEP, or with a halt request pending, returns to HALT.
    always_ff @(posedge clk) begin
        if (reset || (next_state != ST_MEM_WAIT)) begin
            ret_halt <= 1'b0;
        end else if (state == ST_MEM_WAIT) begin
            ret_halt <= ret_halt || halt_req;
        end else begin
            ret_halt <= (state == ST_STEP) || halt_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            mem_error_q <= 1'b0;
        end else begin
            if (freeze) begin
                wait_cnt <= (state == ST_MEM_WAIT) ? (wait_cnt + WAIT_W'(1)) : WAIT_W'(1);
            end
            if (timeout) begin
                mem_error_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != {CNT_WIDTH{1'b1}})) begin
                stall_q <= stall_q + CNT_WIDTH'(1);
            end
            if (flush_inc && (flush_q != {CNT_WIDTH{1'b1}})) begin
                flush_q <= flush_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        pc_write     = ctrl.pc_write;
        if_id_write  = ctrl.if_id_write;
        id_ex_write  = ctrl.id_ex_write;
        ex_mem_write = ctrl.ex_mem_write;
        mem_wb_write = ctrl.mem_wb_write;
        if_id_flush  = ctrl.if_id_flush;
        id_ex_flush  = ctrl.id_ex_flush;
        ex_mem_flush = ctrl.ex_mem_flush;
        mem_error    = mem_error_q && !reset;
        stall_count  = reset ? '0 : stall_q;
        flush_count  = reset ? '0 : flush_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a default instance plus a
// CNT_WIDTH=4 instance sharing the same stimulus for the saturation case.
module tb_pipeline_hazard_controller;

    localparam logic [7:0] C_RST  = 8'b00000_111;
    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_FRZ  = 8'b00000_000;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_RED  = 8'b11111_110;
    localparam logic [7:0] C_JMP  = 8'b11111_100;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
    logic        id_uses_rt, id_jump, id_ex_mem_read, ex_redirect;
    logic        mem_req, mem_ready, halt_req, resume, step;

    logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, halted, mem_error;
    logic [15:0] stall_count, flush_count;

    logic        pc_write4, if_id_write4, id_ex_write4, ex_mem_write4, mem_wb_write4;
    logic        if_id_flush4, id_ex_flush4, ex_mem_flush4, halted4, mem_error4;
    logic [3:0]  stall_count4, flush_count4;

    int check_count = 0;
    int error_count = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller dut (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .halt_req(halt_req), .resume(resume), .step(step),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .halted(halted), .mem_error(mem_error),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_controller #(.CNT_WIDTH(4), .MEM_TIMEOUT(15)) dut4 (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .halt_req(halt_req), .resume(resume), .step(step),
        .pc_write(pc_write4), .if_id_write(if_id_write4), .id_ex_write(id_ex_write4),
        .ex_mem_write(ex_mem_write4), .mem_wb_write(mem_wb_write4),
        .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4), .ex_mem_flush(ex_mem_flush4),
        .halted(halted4), .mem_error(mem_error4),
        .stall_count(stall_count4), .flush_count(flush_count4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic [7:0] expected);
        checkOutput(tag, {24'd0, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                          if_id_flush, id_ex_flush, ex_mem_flush}, {24'd0, expected});
    endtask

    task automatic clearInputs();
        if_id_rs = 5'd0; if_id_rt = 5'd0; id_ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_jump = 1'b0; id_ex_mem_read = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0; step = 1'b0;
    endtask

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                 input logic mem_read, input logic [4:0] ex_rt);
        if_id_rs = rs; if_id_rt = rt; id_uses_rt = uses_rt;
        id_ex_mem_read = mem_read; id_ex_rt = ex_rt;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkCtrl("reset_ctrl", C_RST);
        checkOutput("reset_halted", halted, 0);
        checkOutput("reset_stall", stall_count, 0);
        checkOutput("reset_flush", flush_count, 0);

        reset = 1'b0;
        #1;
        checkCtrl("first_run", C_RUN);
        nextCycle();

        // load-use on rs, then no-stall follow-up
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8);
        checkCtrl("lu_rs", C_LU);
        nextCycle();
        #1;
        checkCtrl("lu_one_bubble", C_RUN);
        checkOutput("lu_stall_1", stall_count, 1);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0);
        checkCtrl("lu_zero_reg", C_RUN);
        nextCycle();
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b1, 5'd9);
        checkCtrl("lu_rt", C_LU);
        nextCycle();
        applyStimulus(5'd3, 5'd9, 1'b0, 1'b1, 5'd9);
        checkCtrl("lu_rt_unused", C_RUN);
        nextCycle();
        #1;
        checkOutput("lu_stall_2", stall_count, 2);
        checkOutput("lu_flush_2", flush_count, 2);

        ex_redirect = 1'b1;
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8);
        checkCtrl("redirect_wins", C_RED);
        nextCycle();
        #1;
        checkOutput("redirect_flush", flush_count, 3);
        checkOutput("redirect_stall", stall_count, 2);
        id_jump = 1'b1;
        #1;
        checkCtrl("jump", C_JMP);
        nextCycle();
        #1;
        checkOutput("jump_flush", flush_count, 4);

        // three-cycle memory wait
        for (int i = 0; i < 3; i++) begin
            mem_req = 1'b1;
            #1;
            checkCtrl($sformatf("mem_frozen_%0d", i), C_FRZ);
            nextCycle();
        end
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        checkCtrl("mem_done", C_RUN);
        nextCycle();
        #1;
        checkOutput("mem_stall", stall_count, 5);
        checkCtrl("mem_back_run", C_RUN);

        // halt request latched during a wait
        mem_req = 1'b1;
        nextCycle();
        mem_req = 1'b1; halt_req = 1'b1;
        #1;
        checkCtrl("mem_halt_latched", C_FRZ);
        nextCycle();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        checkCtrl("mem_halt_done", C_RUN);
        nextCycle();
        #1;
        checkOutput("mem_halt_halted", halted, 1);
        checkCtrl("mem_halt_ctrl", C_FRZ);
        resume = 1'b1;
        nextCycle();
        #1;
        checkOutput("resume_run", halted, 0);
        checkOutput("latched_stall", stall_count, 7);

        // timeout after 15 wait cycles
        for (int i = 1; i <= 15; i++) begin
            mem_req = 1'b1;
            #1;
            if (i == 15) begin
                checkOutput("timeout_pre_halted", halted, 0);
                checkOutput("timeout_pre_error", mem_error, 0);
            end
            nextCycle();
        end
        #1;
        checkOutput("timeout_halted", halted, 1);
        checkOutput("timeout_error", mem_error, 1);
        checkOutput("timeout_stall", stall_count, 22);
        resume = 1'b1;
        nextCycle();
        #1;
        checkOutput("timeout_resume", halted, 0);
        checkOutput("timeout_error_sticky", mem_error, 1);
        checkCtrl("timeout_resume_ctrl", C_RUN);

        // halt then single step
        halt_req = 1'b1;
        #1;
        checkCtrl("halt_req_cycle", C_RUN);
        nextCycle();
        #1;
        checkOutput("halt_entered", halted, 1);
        step = 1'b1;
        nextCycle();
        #1;
        checkOutput("step_not_halted", halted, 0);
        checkCtrl("step_ctrl", C_RUN);
        nextCycle();
        #1;
        checkOutput("step_rehalt", halted, 1);
        checkCtrl("step_rehalt_ctrl", C_FRZ);
        resume = 1'b1; step = 1'b1;
        nextCycle();
        nextCycle();
        #1;
        checkOutput("resume_wins", halted, 0);
        checkCtrl("resume_wins_ctrl", C_RUN);

        // wait during a step returns to HALT
        halt_req = 1'b1;
        nextCycle();
        step = 1'b1;
        nextCycle();
        mem_req = 1'b1;
        #1;
        checkCtrl("step_wait_frozen", C_FRZ);
        nextCycle();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        checkCtrl("step_wait_done", C_RUN);
        nextCycle();
        #1;
        checkOutput("step_wait_halt", halted, 1);

        // reset in the middle of a wait
        resume = 1'b1;
        nextCycle();
        mem_req = 1'b1;
        nextCycle();
        mem_req = 1'b1;
        reset = 1'b1;
        #1;
        checkCtrl("midwait_reset_ctrl", C_RST);
        checkOutput("midwait_reset_stall", stall_count, 0);
        checkOutput("midwait_reset_error", mem_error, 0);
        @(posedge clk); #1;
        checkOutput("midwait_reset_flush", flush_count, 0);
        checkOutput("midwait_reset_halted", halted, 0);
        clearInputs();
        reset = 1'b0;
        #1;
        checkCtrl("post_reset_run", C_RUN);
        checkOutput("post_reset_error", mem_error, 0);
        nextCycle();

        // saturation: 20 load-use stalls
        for (int i = 0; i < 20; i++) begin
            applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 5'd8);
            nextCycle();
        end
        #1;
        checkOutput("sat_stall4", stall_count4, 15);
        checkOutput("sat_stall16", stall_count, 20);
        checkOutput("sat_flush4", flush_count4, 15);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central sequencing block for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It generates every pipeline-register write-enable and flush, and the PC write-enable, from four event sources:
- load-use hazards detected in ID;
- control redirects (taken branch, `jr` resolved in EX; `j`/`jal` resolved in ID);
- data-memory wait handshakes from MEM;
- a debug halt/step port.

It also keeps saturating stall and flush event counters.

## Interface
Parameters:
- `CNT_WIDTH`, 16, width of each event counter
- `MEM_TIMEOUT`, 15, maximum consecutive wait cycles before a memory error is declared

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- `if_id_rs`, `if_id_rt`  in  5 each  source registers of the instruction in ID
- `id_uses_rt`  in  1  instruction in ID reads `rt` (R-type, `beq`, `bne`, `sw`)
- `id_jump`  in  1  `j`/`jal` decoded in ID
- `id_ex_mem_read`  in  1  instruction in EX is `lw`
- `id_ex_rt`  in  5  destination of that `lw`
- `ex_redirect`  in  1  taken branch or `jr` resolved in EX
- `mem_req`  in  1  MEM stage is accessing data memory
- `mem_ready`  in  1  data memory completes the access this cycle
- `halt_req`, `resume`, `step`  in  1 each  debug controls, one-cycle pulses
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`, `mem_wb_write`  out  1 each  register enables
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  load a bubble (all-zero control fields)
- `halted`  out  1  state is HALT
- `mem_error`  out  1  sticky memory timeout flag
- `stall_count`, `flush_count`  out  `CNT_WIDTH` each  event counters

## Operation
- States: RUN, MEM_WAIT, HALT, STEP. State is encoded in 2 bits.
- **MEM_WAIT** (entered or held when `mem_req && !mem_ready`):
  - All five write-enables are 0; all flushes are 0. The whole pipeline freezes.
  - This condition has the highest priority.
- **Redirect** (`ex_redirect`, RUN/STEP, no memory wait):
  - `if_id_flush = 1` and `id_ex_flush = 1`.
  - `pc_write` stays 1, so the PC loads the redirect target.
  - Any load-use hazard or `id_jump` in the same cycle is ignored.
- **Load-use hazard:** `id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || (id_uses_rt && id_ex_rt == if_id_rt))`.
  - `pc_write = 0`, `if_id_write = 0`, `id_ex_flush = 1`.
  - This yields exactly one bubble.
- **Jump** (`id_jump`, no higher-priority event): `if_id_flush = 1`, all writes stay 1.
- **Default:** all writes 1, all flushes 0.
- Counters (saturate at all-ones, never wrap):
  - `stall_count` increments once per load-use cycle and once per MEM_WAIT cycle.
  - `flush_count` increments once per cycle in which any flush output is 1.
- **Transitions:**
  - RUN → MEM_WAIT on `mem_req && !mem_ready`.
  - RUN → HALT on `halt_req`, only when no memory wait is pending.
  - MEM_WAIT → return state when `mem_ready`.
  - MEM_WAIT → HALT with `mem_error = 1` when the wait counter reaches `MEM_TIMEOUT`.
  - HALT → RUN on `resume`.
  - HALT → STEP on `step` (`resume` wins if both are asserted).
  - STEP behaves as RUN for one cycle, then goes to HALT. If a wait starts during STEP, the block goes to MEM_WAIT and returns to HALT when the wait ends.
- **HALT:** all writes 0, all flushes 0, `halted = 1`.
- `mem_error` clears only on `reset`.

## Timing
- Enables and flushes are combinational from the registered state and the current inputs, with no added latency. This is required because the hazard must be acted on in the cycle it appears.
- State, the wait counter, `mem_error` and the event counters update on the rising `clk` edge.
- While `reset = 1`:
  - all write-enables are 0;
  - all three flushes are 1;
  - `halted = 0`, `mem_error = 0`, counters are 0;
  - the next state is RUN.
- Reset mid-wait or mid-step discards the return-state flag.
- First cycle after reset release: default outputs.
- Wait counter:
  - clears on every MEM_WAIT entry;
  - counts MEM_WAIT cycles;
  - a timeout fires on the edge ending wait cycle `MEM_TIMEOUT`.
- `halt_req` during MEM_WAIT is latched and honoured on wait completion.

## Structure
- Shared package `mips_pipe_pkg` holds:
  - the state enum;
  - the bubble constant (all-zero control word);
  - `REG_ZERO = 5'd0`, reused by the forwarding unit.
- One combinational sub-module, `load_use_detector` (the register compares), is instantiated once. Everything else lives in the top.

## Test plan
- **Load-use bubble.** `lw $t0` in EX (`id_ex_rt = 8`), ID `if_id_rs = 8` → for exactly 1 cycle `pc_write = 0`, `if_id_write = 0`, `id_ex_flush = 1`; `stall_count` 0 → 1. The same case with `id_ex_rt = 0` gives no stall.
- **Redirect wins over load-use.** `ex_redirect = 1` and load-use in the same cycle → `if_id_flush = id_ex_flush = 1`, `pc_write = 1`; `flush_count` +1, `stall_count` unchanged.
- **Memory wait.** `mem_req = 1`, `mem_ready = 0` for 3 cycles, then `mem_ready = 1` → 3 frozen cycles, `stall_count = 3`, back to RUN.
- **Memory timeout.** `mem_ready` never asserted → after 15 wait cycles `mem_error = 1`, `halted = 1`; `resume` → RUN, `mem_error` still 1.
- **Step from halt.** `halt_req`, then `step` → exactly one cycle with all writes = 1, then `halted = 1` again; `resume` → RUN.
- **Reset and saturation.** Reset asserted mid-MEM_WAIT → flushes = 1 and counters = 0 during reset; with `CNT_WIDTH = 4`, 20 stalls → `stall_count = 15`.
